adder_tree_pipe: RTL and testbench
==================================

# adder_tree_pipe

Fully pipelined, parametrised reduction tree that sums BANK_SIZE words down to one result per beat. It supports signed or unsigned operands and valid/ready flow control with full-pipeline stall. An accumulator sums successive beats until an `in_last` marker, then emits a single result with an overflow flag. The block sits between a bank of parallel producers (e.g. MAC lanes) and a single downstream consumer. It replaces the single-level pairwise adder stage where a complete reduction is needed.

## Interface

Parameters:
- WORD_SIZE, 8, width of each input word.
- BANK_SIZE, 16, number of input words. Power of two, ≥ 2. L = log2(BANK_SIZE) tree levels.
- SIGNED, 0, 1 = two's-complement operands and results; 0 = unsigned.
- ACC_SIZE, WORD_SIZE+log2(BANK_SIZE)+8, accumulator/result width. Must be ≥ WORD_SIZE+L. Elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_last  input  1  final beat of current packet.
- in  input  WORD_SIZE*BANK_SIZE  packed words; word i = in[(i+1)*WORD_SIZE-1 : i*WORD_SIZE].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  ACC_SIZE  packet sum.
- out_ovf  output  1  accumulator wrapped at least once during this packet.

## Operation

- Global enable: adv = ~out_valid | out_ready. in_ready = adv (combinational, no dependence on in_valid). Beat accepted when in_valid & in_ready at a rising edge.
- Stage 0: when adv, register all BANK_SIZE words, plus valid (= in_valid) and last (= in_last).
- Levels 1..L: level k registers BANK_SIZE/2^k sums of adjacent pairs from level k-1 (words 2j and 2j+1 → j). Each level is width WORD_SIZE+k, extended by one bit (sign-extend if SIGNED, else zero-extend). Valid/last travel alongside. Level L holds one exact sum of width WORD_SIZE+L. No overflow is possible inside the tree.
- All pipeline registers load only when adv. Otherwise all hold (bubbles included).
- Accumulate stage, on adv with level-L valid:
  - Extend the tree sum to ACC_SIZE (sign- or zero-extend per SIGNED). Compute s = acc + sum modulo 2^ACC_SIZE.
  - Overflow of this add: unsigned → carry out of bit ACC_SIZE-1. Signed → operands have the same sign and s has the other sign.
  - If last = 0: acc ← s; ovf_acc ← ovf_acc | overflow.
  - If last = 1: out ← s; out_ovf ← ovf_acc | overflow; out_valid ← 1; acc ← 0; ovf_acc ← 0.
- If out_valid & out_ready and no new result is written that edge, out_valid ← 0.
- A single-beat packet has in_last = 1 on its only beat.
- Bubbles (valid = 0) do not disturb acc.

## Timing

- Reset (rst = 1 at an edge): clears all stage valid bits, stage data, acc, ovf_acc, out, out_ovf and out_valid to 0.
  - in_ready reads 1 in the cycle after reset releases.
  - rst overrides all other activity. A partial packet or held result is discarded, and no output appears for beats accepted before reset.
- Latency: a last beat accepted at edge t gives out_valid = 1 after edge t+L+2. For BANK_SIZE = 16 that is 6 cycles.
- Throughput: one beat per cycle while out_ready = 1 or out_valid = 0.
- Backpressure: while out_valid = 1 and out_ready = 0, in_ready = 0 and every stage, out and out_ovf hold unchanged. No beat is lost or duplicated.
- A result can be consumed and a new one loaded on the same edge (out_valid stays 1).
- Result stability: out and out_ovf change only on an edge where out_valid is loaded.

## Test plan

All scenarios use WORD_SIZE = 8, BANK_SIZE = 16 unless stated.
- Unsigned single beat: all words 0xFF, in_last = 1, out_ready = 1 → out = 4080 (0xFF0), out_valid exactly 6 cycles after acceptance, out_ovf = 0.
- Signed (SIGNED = 1), single beat: all words 0x80 → out = -2048. Then words alternating 0x7F/0x81 → out = 0. Both with out_ovf = 0.
- Multi-beat: three beats of all 0x01 with in_last on beat 3, including one idle cycle between beats 1 and 2 → one result, out = 48. No out_valid pulse on beats 1–2.
- Backpressure: streaming single-beat packets of values 1, 2, 3 (all words equal) with out_ready = 0 for 5 cycles after the first result. The first result (16) is held, in_ready = 0, and results 16, 32, 48 are then delivered in order with no loss.
- Overflow: ACC_SIZE = 12, unsigned, two beats of all 0xFF, last on beat 2 → out = 8160 mod 4096 = 4064, out_ovf = 1. The next packet (one beat of all 0x00) gives out = 0, out_ovf = 0.
- Reset mid-operation: assert rst for 1 cycle after beat 1 of a 2-beat packet. Send a fresh 1-beat packet of all 0x02 → out = 32 with no contribution from the discarded beat. Outputs read 0 and in_ready = 1 in the cycle after reset.

Source files
------------

// File: rtl/adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_pipe
// Purpose  : Fully pipelined binary reduction tree that sums BANK_SIZE words
//            per beat, followed by a packet accumulator. One result (with an
//            overflow flag) is emitted per packet, on the beat marked in_last.
//            All stages share one enable, so downstream backpressure stalls
//            the whole pipeline.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            in_valid  - input beat valid
//            in_ready  - block can accept a beat (== global advance)
//            in_last   - final beat of the current packet
//            in        - BANK_SIZE packed words, word i at [i*WORD_SIZE +: WORD_SIZE]
//            out_valid - result valid
//            out_ready - consumer accepts result
//            out       - packet sum (ACC_SIZE bits)
//            out_ovf   - accumulator wrapped at least once during the packet
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_pipe #(
  parameter int WORD_SIZE = 8,
  parameter int BANK_SIZE = 16,
  parameter bit SIGNED    = 1'b0,
  parameter int ACC_SIZE  = WORD_SIZE + $clog2(BANK_SIZE) + 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [WORD_SIZE*BANK_SIZE-1:0] in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_SIZE-1:0]            out,
  output logic                           out_ovf
);

  localparam int c_L  = $clog2(BANK_SIZE);
  localparam int c_TW = WORD_SIZE + c_L;   // exact width of the tree sum

  // --------------------------------------------------------------------------
  // Parameter sanity
  // --------------------------------------------------------------------------
  if (BANK_SIZE < 2 || (BANK_SIZE & (BANK_SIZE - 1)) != 0) begin : g_bad_bank
    $error("adder_tree_pipe: BANK_SIZE must be a power of two >= 2");
  end
  if (ACC_SIZE < c_TW) begin : g_bad_acc
    $error("adder_tree_pipe: ACC_SIZE must be >= WORD_SIZE + log2(BANK_SIZE)");
  end

  // --------------------------------------------------------------------------
  // Global advance: every pipeline register moves only when the output slot
  // is free or being drained this edge.
  // --------------------------------------------------------------------------
  logic w_adv;
  logic r_out_valid;

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;

  // --------------------------------------------------------------------------
  // Valid/last sideband: index 0 = input register, 1..L = tree levels,
  // L+1 = extension register feeding the accumulator.
  // --------------------------------------------------------------------------
  logic [c_L+1:0] r_vld;
  logic [c_L+1:0] r_lst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_lst <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[c_L:0], in_valid};
      r_lst <= {r_lst[c_L:0], in_last};
    end
  end

  // --------------------------------------------------------------------------
  // Reduction tree. Level k holds BANK_SIZE>>k words of WORD_SIZE+k bits;
  // each pair from level k-1 is extended by one bit before adding, so the
  // tree can never overflow.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k <= c_L; k++) begin : g_level
    localparam int c_N = BANK_SIZE >> k;
    localparam int c_W = WORD_SIZE + k;

    logic [c_N*c_W-1:0] r_data;

    if (k == 0) begin : g_in
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_adv) begin
          r_data <= in;
        end
      end
    end else begin : g_sum
      localparam int c_PW = c_W - 1;

      logic [c_N*c_W-1:0] w_sum;

      for (genvar j = 0; j < c_N; j++) begin : g_pair
        logic [c_PW-1:0] w_a;
        logic [c_PW-1:0] w_b;

        assign w_a = g_level[k-1].r_data[(2*j)*c_PW   +: c_PW];
        assign w_b = g_level[k-1].r_data[(2*j+1)*c_PW +: c_PW];

        if (SIGNED) begin : g_signed
          assign w_sum[j*c_W +: c_W] = {w_a[c_PW-1], w_a} + {w_b[c_PW-1], w_b};
        end else begin : g_unsigned
          assign w_sum[j*c_W +: c_W] = {1'b0, w_a} + {1'b0, w_b};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_adv) begin
          r_data <= w_sum;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Extension stage: widen the exact tree sum to accumulator width.
  // --------------------------------------------------------------------------
  logic [c_TW-1:0]     w_tree;
  logic [ACC_SIZE-1:0] w_ext;
  logic [ACC_SIZE-1:0] r_ext;

  assign w_tree = g_level[c_L].r_data;

  if (SIGNED) begin : g_ext_signed
    assign w_ext = ACC_SIZE'($signed(w_tree));
  end else begin : g_ext_unsigned
    assign w_ext = ACC_SIZE'(w_tree);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext <= '0;
    end else if (w_adv) begin
      r_ext <= w_ext;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator and result register
  // --------------------------------------------------------------------------
  logic [ACC_SIZE-1:0] r_acc;
  logic                r_ovf_acc;
  logic [ACC_SIZE-1:0] r_out;
  logic                r_out_ovf;
  logic [ACC_SIZE:0]   w_full;
  logic [ACC_SIZE-1:0] w_s;
  logic                w_ovf;
  logic                w_take;
  logic                w_load;

  assign w_full = {1'b0, r_acc} + {1'b0, r_ext};
  assign w_s    = w_full[ACC_SIZE-1:0];

  // Unsigned: carry out. Signed: same-sign operands producing opposite sign.
  assign w_ovf = SIGNED ? ((r_acc[ACC_SIZE-1] == r_ext[ACC_SIZE-1]) &&
                           (w_s[ACC_SIZE-1]   != r_acc[ACC_SIZE-1]))
                        : w_full[ACC_SIZE];

  assign w_take = w_adv & r_vld[c_L+1];
  assign w_load = w_take & r_lst[c_L+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out       <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_take) begin
        if (r_lst[c_L+1]) begin
          r_out     <= w_s;
          r_out_ovf <= r_ovf_acc | w_ovf;
          r_acc     <= '0;
          r_ovf_acc <= 1'b0;
        end else begin
          r_acc     <= w_s;
          r_ovf_acc <= r_ovf_acc | w_ovf;
        end
      end

      // A new result wins over consumption, so back-to-back results keep
      // out_valid high.
      if (w_load) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_pipe
// Purpose  : Directed self-checking bench for adder_tree_pipe. Three instances
//            share one stimulus stream: unsigned (ACC 20), signed (ACC 20) and
//            unsigned with a narrow 12-bit accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_pipe;

  localparam int WS = 8;
  localparam int BS = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_last;
  logic [WS*BS-1:0] in_bus;
  logic            out_ready;

  logic            u_in_ready, u_out_valid, u_ovf;
  logic [19:0]     u_out;
  logic            s_in_ready, s_out_valid, s_ovf;
  logic [19:0]     s_out;
  logic            o_in_ready, o_out_valid, o_ovf;
  logic [11:0]     o_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_tree_pipe #(.WORD_SIZE(WS), .BANK_SIZE(BS), .SIGNED(1'b0), .ACC_SIZE(20)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_last(in_last),
    .in(in_bus), .out_valid(u_out_valid), .out_ready(out_ready), .out(u_out), .out_ovf(u_ovf));

  adder_tree_pipe #(.WORD_SIZE(WS), .BANK_SIZE(BS), .SIGNED(1'b1), .ACC_SIZE(20)) s_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last),
    .in(in_bus), .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out), .out_ovf(s_ovf));

  adder_tree_pipe #(.WORD_SIZE(WS), .BANK_SIZE(BS), .SIGNED(1'b0), .ACC_SIZE(12)) o_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready), .in_last(in_last),
    .in(in_bus), .out_valid(o_out_valid), .out_ready(out_ready), .out(o_out), .out_ovf(o_ovf));

  function automatic logic [WS*BS-1:0] fill(input logic [7:0] w);
    logic [WS*BS-1:0] v;
    for (int i = 0; i < BS; i++) v[i*WS +: WS] = w;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [WS*BS-1:0] d, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    in_bus   = d;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts edges until a result appears; bounded so a dead DUT cannot hang.
  task automatic wait_result(output int n);
    n = 0;
    while (u_out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_bus = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", u_out_valid); end
    checks++; if (u_out !== 20'd0) begin errors++; $display("FAIL reset_out got %0d expected 0", u_out); end
    checks++; if (u_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b expected 0", u_ovf); end
    checks++; if (u_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", u_in_ready); end
  endtask

  task automatic test_unsigned_single;
    int n;
    send_beat(fill(8'hFF), 1'b1);
    wait_result(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL uns_latency got %0d expected 6", n); end
    checks++; if (u_out !== 20'd4080) begin errors++; $display("FAIL uns_sum got %0d expected 4080", u_out); end
    checks++; if (u_ovf !== 1'b0) begin errors++; $display("FAIL uns_ovf got %0b expected 0", u_ovf); end
    step();
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL uns_drain got %0b expected 0", u_out_valid); end
  endtask

  task automatic test_signed;
    int n;
    logic [WS*BS-1:0] alt;
    send_beat(fill(8'h80), 1'b1);
    wait_result(n);
    checks++; if (s_out !== 20'hFF800) begin errors++; $display("FAIL sgn_neg got %h expected ff800", s_out); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL sgn_neg_ovf got %0b expected 0", s_ovf); end
    step();
    for (int i = 0; i < BS; i++) alt[i*WS +: WS] = (i % 2 == 0) ? 8'h7F : 8'h81;
    send_beat(alt, 1'b1);
    wait_result(n);
    checks++; if (s_out !== 20'd0) begin errors++; $display("FAIL sgn_alt got %h expected 0", s_out); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL sgn_alt_ovf got %0b expected 0", s_ovf); end
    step();
  endtask

  task automatic test_multi_beat;
    int n;
    send_beat(fill(8'h01), 1'b0);
    step();
    send_beat(fill(8'h01), 1'b0);
    send_beat(fill(8'h01), 1'b1);
    wait_result(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL multi_latency got %0d expected 6", n); end
    checks++; if (u_out !== 20'd48) begin errors++; $display("FAIL multi_sum got %0d expected 48", u_out); end
    step();
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL multi_single_pulse got %0b expected 0", u_out_valid); end
  endtask

  task automatic test_back_to_back;
    int n;
    int bad;
    logic [19:0] got[$];
    in_valid = 1'b1; in_last = 1'b1;
    in_bus = fill(8'h01); step();
    in_bus = fill(8'h02); step();
    in_bus = fill(8'h03); step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(n);
    out_ready = 1'b0;
    checks++; if (u_out !== 20'd16) begin errors++; $display("FAIL bp_first got %0d expected 16", u_out); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (u_out_valid !== 1'b1 || u_out !== 20'd16 || u_in_ready !== 1'b0 ||
          s_in_ready !== 1'b0 || o_in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles expected 0", bad); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (u_out_valid === 1'b1) got.push_back(u_out);
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL bp_count got %0d expected 2", got.size()); end
    checks++; if (got.size() < 1 || got[0] !== 20'd32) begin errors++; $display("FAIL bp_second got %0d expected 32", (got.size() > 0) ? got[0] : 20'd0); end
    checks++; if (got.size() < 2 || got[1] !== 20'd48) begin errors++; $display("FAIL bp_third got %0d expected 48", (got.size() > 1) ? got[1] : 20'd0); end
  endtask

  task automatic test_overflow;
    int n;
    send_beat(fill(8'hFF), 1'b0);
    send_beat(fill(8'hFF), 1'b1);
    wait_result(n);
    checks++; if (o_out !== 12'd4064) begin errors++; $display("FAIL ovf_sum got %0d expected 4064", o_out); end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b expected 1", o_ovf); end
    checks++; if (u_out !== 20'd8160 || u_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wide got %0d/%0b expected 8160/0", u_out, u_ovf); end
    step();
    send_beat(fill(8'h00), 1'b1);
    wait_result(n);
    checks++; if (o_out !== 12'd0) begin errors++; $display("FAIL ovf_next_sum got %0d expected 0", o_out); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %0b expected 0", o_ovf); end
    step();
  endtask

  task automatic test_reset_mid;
    int n;
    // Park a result, then reset must drop it.
    out_ready = 1'b0;
    send_beat(fill(8'h03), 1'b1);
    wait_result(n);
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (u_out_valid !== 1'b0 || u_out !== 20'd0 || u_ovf !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs got %0b/%0d/%0b expected 0/0/0", u_out_valid, u_out, u_ovf); end
    checks++; if (u_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b expected 1", u_in_ready); end
    out_ready = 1'b1;
    // Partial packet already in the accumulator.
    send_beat(fill(8'h05), 1'b0);
    repeat (8) step();
    rst = 1'b1; step(); rst = 1'b0;
    // Partial packet still inside the tree.
    send_beat(fill(8'h05), 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    send_beat(fill(8'h02), 1'b1);
    wait_result(n);
    checks++; if (n !== 6) begin errors++; $display("FAIL rstmid_latency got %0d expected 6", n); end
    checks++; if (u_out !== 20'd32) begin errors++; $display("FAIL rstmid_sum got %0d expected 32", u_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned_single();
    test_signed();
    test_multi_beat();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
